spectro_frame_receiver: RTL and testbench

- Far-end deserializer for the spectrogram extractor's serial readout link.
- Samples the link signals serial, SL load strobe, channel address a[3:0] and ovf, and rebuilds 12-bit words tagged with their channel number.
- Word 0 is the RTC timestamp (min[11:6], sec[5:0]); words 1..15 are channel counts.
- Presents each word on a valid/ready port, flags frame completion and reports link errors. It sits in the host-side FPGA/test harness on the same clock as the transmitter.

---
 rtl/spectro_frame_receiver.sv | 187 ++++++++++++++++++
 tb/tb_spectro_frame_receiver.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spectro_frame_receiver.sv
// Far-end deserializer for the spectrogram extractor's serial readout link.
// Rebuilds WORD_W-bit words (MSB first) framed by the SL strobe, tags them
// with the latched channel address and offers them on a valid/ready port.
// Optional: define SEQ_CHECK_EN to add the channel-sequence checker (seq_err).
module spectro_frame_receiver #(
    parameter int unsigned WORD_W = 12,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned N_CH   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              serial_in,
    input  logic              sl_in,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic              ovf_in,
    output logic [WORD_W-1:0] word_data,
    output logic [ADDR_W-1:0] word_ch,
    output logic              word_valid,
    input  logic              word_ready,
    output logic              frame_done,
    output logic              overrun,
    output logic              short_err,
    input  logic              err_clr
`ifdef SEQ_CHECK_EN
    ,
    output logic              seq_err
`endif
);

    localparam int unsigned       CntW    = $clog2(WORD_W + 1);
    localparam logic [CntW-1:0]   LastBit = CntW'(WORD_W - 1);
    localparam logic [ADDR_W-1:0] LastCh  = ADDR_W'(N_CH - 1);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [ADDR_W-1:0] ch_lat_q, ch_lat_d;
    logic              ovf_q;

    logic [WORD_W-1:0] word_data_q, word_data_d;
    logic [ADDR_W-1:0] word_ch_q, word_ch_d;
    logic              word_valid_q, word_valid_d;
    logic              frame_done_q, frame_done_d;
    logic              overrun_q, overrun_d;
    logic              short_err_q, short_err_d;

    logic [WORD_W-1:0] shreg_next;
    logic              complete;
    logic              short_set;

    assign shreg_next = {shreg_q[WORD_W-2:0], serial_in};

    // Framing FSM: SL opens a word, WORD_W shifted bits close it, SL/ovf rise abort it.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        ch_lat_d  = ch_lat_q;
        complete  = 1'b0;
        short_set = 1'b0;
        case (state_q)
            StIdle: begin
                if (sl_in) begin
                    ch_lat_d  = addr_in;
                    bit_cnt_d = '0;
                    shreg_d   = '0;
                    state_d   = StShift;
                end
            end
            StShift: begin
                if (ovf_in && !ovf_q) begin
                    // Overflow rising mid-word means the frame restarted under us.
                    short_set = 1'b1;
                    bit_cnt_d = '0;
                    shreg_d   = '0;
                    state_d   = StIdle;
                end else if (sl_in) begin
                    short_set = 1'b1;
                    ch_lat_d  = addr_in;
                    bit_cnt_d = '0;
                    shreg_d   = '0;
                end else begin
                    shreg_d   = shreg_next;
                    bit_cnt_d = bit_cnt_q + CntW'(1);
                    if (bit_cnt_q == LastBit) begin
                        complete  = 1'b1;
                        bit_cnt_d = '0;
                        state_d   = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Holding register, handshake and sticky error flags.
    always_comb begin
        word_data_d  = word_data_q;
        word_ch_d    = word_ch_q;
        word_valid_d = word_valid_q;
        frame_done_d = 1'b0;
        overrun_d    = overrun_q & ~err_clr;
        short_err_d  = (short_err_q & ~err_clr) | short_set;
        if (complete && (!word_valid_q || word_ready)) begin
            word_data_d  = shreg_next;
            word_ch_d    = ch_lat_q;
            word_valid_d = 1'b1;
            frame_done_d = (ch_lat_q == LastCh);
        end else begin
            if (complete) begin
                overrun_d = 1'b1;
            end
            if (word_valid_q && word_ready) begin
                word_valid_d = 1'b0;
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            ch_lat_q     <= '0;
            ovf_q        <= 1'b0;
            word_data_q  <= '0;
            word_ch_q    <= '0;
            word_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
            short_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            ch_lat_q     <= ch_lat_d;
            ovf_q        <= ovf_in;
            word_data_q  <= word_data_d;
            word_ch_q    <= word_ch_d;
            word_valid_q <= word_valid_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
            short_err_q  <= short_err_d;
        end
    end

    assign word_data  = word_data_q;
    assign word_ch    = word_ch_q;
    assign word_valid = word_valid_q;
    assign frame_done = frame_done_q;
    assign overrun    = overrun_q;
    assign short_err  = short_err_q;

`ifdef SEQ_CHECK_EN
    logic [ADDR_W-1:0] exp_ch_q, exp_ch_d;
    logic              seq_err_q, seq_err_d;

    // Channel sequence check on every completed word, dropped or not.
    always_comb begin
        exp_ch_d  = exp_ch_q;
        seq_err_d = seq_err_q & ~err_clr;
        if (complete) begin
            if (ch_lat_q != exp_ch_q) begin
                seq_err_d = 1'b1;
            end
            exp_ch_d = (ch_lat_q == LastCh) ? '0 : ch_lat_q + ADDR_W'(1);
        end
    end

    // Sequence checker registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_ch_q  <= '0;
            seq_err_q <= 1'b0;
        end else begin
            exp_ch_q  <= exp_ch_d;
            seq_err_q <= seq_err_d;
        end
    end

    assign seq_err = seq_err_q;
`endif

endmodule

// File: tb/tb_spectro_frame_receiver.sv
// Scoreboard bench for spectro_frame_receiver: expected {ch, data} words are
// queued as they are driven and popped when the DUT presents a new word.
module tb_spectro_frame_receiver;

    logic        clk = 1'b0;
    logic        reset;
    logic        serial_in;
    logic        sl_in;
    logic [3:0]  addr_in;
    logic        ovf_in;
    logic [11:0] word_data;
    logic [3:0]  word_ch;
    logic        word_valid;
    logic        word_ready;
    logic        frame_done;
    logic        overrun;
    logic        short_err;
    logic        err_clr;
`ifdef SEQ_CHECK_EN
    logic        seq_err;
`endif

    spectro_frame_receiver #(
        .WORD_W (12),
        .ADDR_W (4),
        .N_CH   (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .serial_in  (serial_in),
        .sl_in      (sl_in),
        .addr_in    (addr_in),
        .ovf_in     (ovf_in),
        .word_data  (word_data),
        .word_ch    (word_ch),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .frame_done (frame_done),
        .overrun    (overrun),
        .short_err  (short_err),
        .err_clr    (err_clr)
`ifdef SEQ_CHECK_EN
        ,
        .seq_err    (seq_err)
`endif
    );

    always #5 clk = ~clk;

    int          n_cmp    = 0;
    int          n_bad    = 0;
    int          fd_count = 0;
    logic        v_prev   = 1'b0;
    logic [15:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // A new word is on the port when valid is high and the previous one was absent or taken.
    always @(posedge clk) begin : monitor
        logic [15:0] e;
        #1;
        if (reset) begin
            v_prev = 1'b0;
        end else begin
            if (frame_done) fd_count++;
            if (word_valid && (!v_prev || word_ready)) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_word", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("word_data", word_data, e[11:0]);
                    check_eq("word_ch", word_ch, e[15:12]);
                    check_eq("frame_done", frame_done, e[15:12] == 4'd15);
                end
            end
            v_prev = word_valid;
        end
    end

    task automatic drive(input logic sl, input logic ser);
        @(negedge clk);
        sl_in     = sl;
        serial_in = ser;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0);
    endtask

    task automatic start_word(input logic [3:0] a);
        @(negedge clk);
        addr_in   = a;
        sl_in     = 1'b1;
        serial_in = 1'b0;
    endtask

    task automatic send_bits(input logic [11:0] d, input int n);
        for (int i = 11; i > 11 - n; i--) drive(1'b0, d[i]);
    endtask

    task automatic send_word(input logic [3:0] a, input logic [11:0] d, input logic expect_it);
        if (expect_it) exp_q.push_back({a, d});
        start_word(a);
        send_bits(d, 12);
    endtask

    task automatic pulse_err_clr();
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b1;
        sl_in     = 1'b0;
        serial_in = 1'b0;
        ovf_in    = 1'b0;
        err_clr   = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_valid"}, word_valid, 0);
        check_eq({tag, "_data"}, word_data, 0);
        check_eq({tag, "_ch"}, word_ch, 0);
        check_eq({tag, "_frame_done"}, frame_done, 0);
        check_eq({tag, "_overrun"}, overrun, 0);
        check_eq({tag, "_short_err"}, short_err, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        serial_in  = 1'b0;
        sl_in      = 1'b0;
        addr_in    = 4'd0;
        ovf_in     = 1'b0;
        word_ready = 1'b1;
        err_clr    = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;

        // Single word with latency check.
        send_word(4'd5, 12'hA5C, 1'b1);
        check_eq("t1_valid_early", word_valid, 0);
        @(posedge clk);
        #1;
        check_eq("t1_valid_rise", word_valid, 1);
        @(posedge clk);
        #1;
        check_eq("t1_valid_fall", word_valid, 0);
        check_eq("t1_overrun", overrun, 0);
        check_eq("t1_short_err", short_err, 0);

        // Full frame, back to back.
        fd_count = 0;
        for (int c = 0; c < 16; c++) send_word(4'(c), 12'(c * 12'h111), 1'b1);
        idle(3);
        check_eq("t2_frame_done_count", fd_count, 1);
        check_eq("t2_queue_empty", exp_q.size(), 0);

        // Backpressure: second word dropped.
        word_ready = 1'b0;
        send_word(4'd1, 12'h123, 1'b1);
        send_word(4'd2, 12'h456, 1'b0);
        idle(2);
        check_eq("t3_valid_held", word_valid, 1);
        check_eq("t3_data_held", word_data, 12'h123);
        check_eq("t3_ch_held", word_ch, 1);
        check_eq("t3_overrun_set", overrun, 1);
        pulse_err_clr();
        check_eq("t3_overrun_clr", overrun, 0);
        @(negedge clk);
        word_ready = 1'b1;
        idle(2);
        check_eq("t3_valid_drained", word_valid, 0);

        // Accept and complete on the same edge.
        word_ready = 1'b0;
        send_word(4'd3, 12'h789, 1'b1);
        send_word(4'd4, 12'hABC, 1'b1);
        word_ready = 1'b1;
        @(posedge clk);
        #1;
        check_eq("t4_valid_kept", word_valid, 1);
        check_eq("t4_data_new", word_data, 12'hABC);
        check_eq("t4_ch_new", word_ch, 4);
        check_eq("t4_overrun", overrun, 0);
        idle(2);

        // ovf rising mid-word aborts it; trailing bits are ignored in IDLE.
        check_eq("t7_short_err_pre", short_err, 0);
        start_word(4'd2);
        send_bits(12'hFFF, 4);
        @(negedge clk);
        ovf_in    = 1'b1;
        serial_in = 1'b1;
        send_bits(12'hFFF, 8);
        idle(2);
        check_eq("t7_short_err", short_err, 1);
        ovf_in = 1'b0;
        send_word(4'd11, 12'h0F0, 1'b1);
        idle(2);
        check_eq("t7_queue_empty", exp_q.size(), 0);

        // Short word followed by a full word.
        pulse_err_clr();
        check_eq("t5_short_err_clr", short_err, 0);
        start_word(4'd6);
        send_bits(12'h3C3, 7);
        send_word(4'd7, 12'h3C3, 1'b1);
        idle(2);
        check_eq("t5_short_err_set", short_err, 1);
        check_eq("t5_queue_empty", exp_q.size(), 0);

        // Asynchronous reset in the middle of a word.
        word_ready = 1'b0;
        send_word(4'd10, 12'h5A5, 1'b1);
        start_word(4'd9);
        send_bits(12'hFFF, 5);
        check_eq("t5_valid_pre_reset", word_valid, 1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_all_zero("t5_async_reset");
        @(negedge clk);
        @(negedge clk);
        reset      = 1'b0;
        sl_in      = 1'b0;
        word_ready = 1'b1;
        send_word(4'd12, 12'h111, 1'b1);
        idle(3);
        check_eq("t5_post_reset_queue", exp_q.size(), 0);

`ifdef SEQ_CHECK_EN
        do_reset();
        check_eq("t6_seq_err_reset", seq_err, 0);
        send_word(4'd0, 12'h100, 1'b1);
        send_word(4'd1, 12'h101, 1'b1);
        idle(1);
        check_eq("t6_seq_err_in_order", seq_err, 0);
        send_word(4'd3, 12'h103, 1'b1);
        idle(1);
        check_eq("t6_seq_err_gap", seq_err, 1);
        pulse_err_clr();
        check_eq("t6_seq_err_clr", seq_err, 0);
        for (int c = 4; c < 16; c++) send_word(4'(c), 12'(c), 1'b1);
        send_word(4'd0, 12'h200, 1'b1);
        idle(2);
        check_eq("t6_seq_err_wrap", seq_err, 0);
        check_eq("t6_queue_empty", exp_q.size(), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
